// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the decode stage.
//   id_ex_data_t : registered ID/EX bundle (instruction, PCs, operands,
//                  immediate, destination and decoded control).
//   uses_rs_t    : which source registers an opcode actually reads.
package core_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
    // ALU_BR: compare for branch, ALU_LUI: pass operand B through
    typedef enum logic [2:0] {ALU_ADD, ALU_BR, ALU_R, ALU_I, ALU_LUI} alu_op_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } uses_rs_t;

    typedef struct packed {
        logic [31:0]               instr;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     rd_data1;
        logic [DATA_WIDTH-1:0]     rd_data2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        imm_sel_e                  imm_sel;
        logic                      alu_src_a;  // 1 = PC
        logic                      alu_src_b;  // 1 = immediate
        alu_op_e                   alu_op;
        logic                      branch;
        logic                      jump;
        logic                      mem_write;
        logic                      mem_read;
        logic                      reg_write;
        wb_sel_e                   wb_sel;
    } id_ex_data_t;

    // Only real operand reads may raise a load-use hazard; the rs fields of
    // U/J formats are immediate bits.
    function automatic uses_rs_t uses_rs(input logic [6:0] opc);
        uses_rs_t u;
        u = '0;
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin u.rs1 = 1'b1; u.rs2 = 1'b1; end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: u.rs1 = 1'b1;
            default: ;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/immediate_generator.sv
// immediate_generator: sign-extended immediate for the I/S/B/U/J formats.
//   instr_i   : instruction[31:7] (opcode not needed)
//   imm_sel_i : format select (imm_sel_e)
//   imm_o     : DATA_WIDTH immediate
module immediate_generator import core_pkg::*; (
    input  logic [31:7]           instr_i,
    input  logic [2:0]            imm_sel_i,
    output logic [DATA_WIDTH-1:0] imm_o
);

    always_comb begin
        case (imm_sel_e'(imm_sel_i))
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
        endcase
    end

endmodule

// File: rtl/main_control_unit.sv
// main_control_unit: opcode -> control signals.
//   opcode_i    : instruction[6:0]
//   *_o         : ImmSel, ALUSrcA/B, ALUOp, Branch, Jump, MemWrite,
//                 MemRead, RegWrite, WBSel. Unknown opcodes decode to a NOP.
module main_control_unit import core_pkg::*; (
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_sel_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       branch_o,
    output logic       jump_o,
    output logic       mem_write_o,
    output logic       mem_read_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o
);

    always_comb begin
        imm_sel_o   = IMM_I;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        alu_op_o    = ALU_ADD;
        branch_o    = 1'b0;
        jump_o      = 1'b0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = WB_ALU;
        case (opcode_i)
            OPC_OP:     begin alu_op_o = ALU_R; reg_write_o = 1'b1; end
            OPC_OPIMM:  begin alu_op_o = ALU_I; alu_src_b_o = 1'b1; reg_write_o = 1'b1; end
            OPC_LOAD:   begin alu_src_b_o = 1'b1; mem_read_o = 1'b1; reg_write_o = 1'b1; wb_sel_o = WB_MEM; end
            OPC_STORE:  begin imm_sel_o = IMM_S; alu_src_b_o = 1'b1; mem_write_o = 1'b1; end
            OPC_BRANCH: begin imm_sel_o = IMM_B; alu_op_o = ALU_BR; branch_o = 1'b1; end
            OPC_JAL:    begin imm_sel_o = IMM_J; alu_src_a_o = 1'b1; alu_src_b_o = 1'b1;
                              jump_o = 1'b1; reg_write_o = 1'b1; wb_sel_o = WB_PC4; end
            OPC_JALR:   begin alu_src_b_o = 1'b1; jump_o = 1'b1; reg_write_o = 1'b1; wb_sel_o = WB_PC4; end
            OPC_LUI:    begin imm_sel_o = IMM_U; alu_src_b_o = 1'b1; alu_op_o = ALU_LUI; reg_write_o = 1'b1; end
            OPC_AUIPC:  begin imm_sel_o = IMM_U; alu_src_a_o = 1'b1; alu_src_b_o = 1'b1; reg_write_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2-read / 1-write register file, x0 hardwired to zero.
//   we_i/waddr_i/wdata_i : write port, written on the rising clk edge
//   raddr*_i/rdata*_o    : combinational read ports
//   BYPASS_EN = 1 forwards a same-cycle write to the read ports.
module regfile_bypass #(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS_EN  = 1,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr1_i,
    input  logic [AW-1:0]         raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q;
    logic                                 wr_live;

    // A write to x0 is dropped here, so it can never be forwarded either.
    assign wr_live = we_i && (waddr_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          regs_q <= '0;
        else if (wr_live) regs_q[waddr_i] <= wdata_i;
    end

    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        if (BYPASS_EN != 0 && wr_live && raddr1_i == waddr_i) rdata1_o = wdata_i;
        if (BYPASS_EN != 0 && wr_live && raddr2_i == waddr_i) rdata2_o = wdata_i;
        if (raddr1_i == '0) rdata1_o = '0;
        if (raddr2_i == '0) rdata2_o = '0;
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: decode stage with ID/EX register.
//   in_valid/in_ready/in_instr/in_pc/in_pc_plus4 : fetch side handshake
//   flush_i                                      : EX redirect, kills ID/EX
//   wb_regwrite_i/wb_addr_i/wb_data_i            : write-back port
//   out_valid/out_ready/out_data                 : EX side, registered bundle
// One-cycle bubble on a load-use hazard against the instruction in ID/EX.
module id_stage_pipelined #(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
    parameter int REG_COUNT  = 32,
    parameter int BYPASS_EN  = 1,
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [31:0]                               in_instr,
    input  logic [DATA_WIDTH-1:0]                     in_pc,
    input  logic [DATA_WIDTH-1:0]                     in_pc_plus4,
    input  logic                                      flush_i,
    input  logic                                      wb_regwrite_i,
    input  logic [REG_ADDR_WIDTH-1:0]                 wb_addr_i,
    input  logic [DATA_WIDTH-1:0]                     wb_data_i,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [$bits(core_pkg::id_ex_data_t)-1:0]  out_data
);
    import core_pkg::*;

    logic [6:0]            opc;
    logic [4:0]            rs1, rs2, rd;
    logic [2:0]            c_imm_sel, c_alu_op;
    logic [1:0]            c_wb_sel;
    logic                  c_src_a, c_src_b, c_branch, c_jump, c_mw, c_mr, c_rw;
    logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2, imm;
    uses_rs_t              uses;
    logic                  stall, advance;
    id_ex_data_t           dec_d, out_q;
    logic                  out_valid_q;

    assign opc = in_instr[6:0];
    assign rd  = in_instr[11:7];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];

    main_control_unit u_ctrl (
        .opcode_i    (opc),
        .imm_sel_o   (c_imm_sel),
        .alu_src_a_o (c_src_a),
        .alu_src_b_o (c_src_b),
        .alu_op_o    (c_alu_op),
        .branch_o    (c_branch),
        .jump_o      (c_jump),
        .mem_write_o (c_mw),
        .mem_read_o  (c_mr),
        .reg_write_o (c_rw),
        .wb_sel_o    (c_wb_sel)
    );

    immediate_generator u_imm (
        .instr_i   (in_instr[31:7]),
        .imm_sel_i (c_imm_sel),
        .imm_o     (imm)
    );

    regfile_bypass #(
        .REG_COUNT  (REG_COUNT),
        .DATA_WIDTH (DATA_WIDTH),
        .BYPASS_EN  (BYPASS_EN)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_regwrite_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1[REG_ADDR_WIDTH-1:0]),
        .raddr2_i (rs2[REG_ADDR_WIDTH-1:0]),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    always_comb begin
        dec_d           = '0;
        dec_d.instr     = in_instr;
        dec_d.pc        = in_pc;
        dec_d.pc_plus4  = in_pc_plus4;
        dec_d.rd_data1  = rf_rd1;
        dec_d.rd_data2  = rf_rd2;
        dec_d.imm       = imm;
        dec_d.rd_addr   = c_rw ? rd : '0;  // no destination -> never a hazard source
        dec_d.imm_sel   = imm_sel_e'(c_imm_sel);
        dec_d.alu_src_a = c_src_a;
        dec_d.alu_src_b = c_src_b;
        dec_d.alu_op    = alu_op_e'(c_alu_op);
        dec_d.branch    = c_branch;
        dec_d.jump      = c_jump;
        dec_d.mem_write = c_mw;
        dec_d.mem_read  = c_mr;
        dec_d.reg_write = c_rw;
        dec_d.wb_sel    = wb_sel_e'(c_wb_sel);
    end

    assign uses  = uses_rs(opc);
    assign stall = out_valid_q && out_q.mem_read && (out_q.rd_addr != '0) && in_valid &&
                   ((uses.rs1 && rs1 == out_q.rd_addr) || (uses.rs2 && rs2 == out_q.rd_addr));

    assign advance  = out_ready || !out_valid_q;
    // A flushed word is consumed and dropped, so fetch may always move on.
    assign in_ready = flush_i || (advance && !stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (advance && stall) begin
            out_valid_q <= 1'b0;  // bubble; the load moves on to EX
        end else if (advance && in_valid) begin
            out_valid_q <= 1'b1;
            out_q       <= dec_d;
        end else if (advance) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule
